serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 24 ++
 rtl/baud_gen.sv | 32 +++
 rtl/serial_tx.sv | 140 ++++++++++++++
 tb/tb_serial_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter: FSM state encoding,
// line levels and default bit-period / frame-width settings.
package serial_pkg;

  localparam int DEFAULT_DIVISOR    = 868;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: counts 0..DIVISOR-1 and flags the final cycle of each period.
// Held at zero while i_clr is high so a new frame always starts a full period.
module baud_gen
  import serial_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = cnt_width(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DIVISOR    = DEFAULT_DIVISOR,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  tx_out,
  output logic                  busy_out
);

  localparam int            IW       = cnt_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [IW-1:0]         r_bit_idx;
  logic [IW-1:0]         w_bit_idx_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  w_idle;
  logic                  w_tick;
`ifdef SERIAL_TX_PARITY_EN
  logic                  r_parity;
  logic                  w_parity_nxt;
`endif

  assign w_idle = (r_state == S_IDLE);

  // Timer is parked while idle, so every frame begins with a full start bit.
  baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud_gen (
    .i_clk  (clk_in),
    .i_rst  (rst_in),
    .i_clr  (w_idle),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= STOP_BIT;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
`ifdef SERIAL_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = data_in;
          w_bit_idx_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
          // Parity is captured up front because the shift register drains.
          w_parity_nxt  = ^data_in;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == LAST_BIT) begin
            w_bit_idx_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt   = S_PARITY;
`else
            w_state_nxt   = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // The line level is decoded from the next state so tx_out is a pure flop.
    case (w_state_nxt)
      S_START:  w_tx_nxt = START_BIT;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
      default:  w_tx_nxt = STOP_BIT;
    endcase
  end

  assign tx_out    = r_tx;
  assign ready_out = w_idle;
  assign busy_out  = ~w_idle;

endmodule

// File: tb/tb_serial_tx.sv
// Randomised bench for serial_tx: a bit-list frame model is compared against the
// serial line, ready and busy every cycle at DIVISOR=4.
module tb_serial_tx;

  localparam int DIV = 4;
  localparam int DW  = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          tx_out;
  logic          busy_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  serial_tx #(
    .DIVISOR    (DIV),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .busy_out  (busy_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle line: {tx, ready, busy} = 1,1,0 for the given number of cycles.
  task automatic expect_idle(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clk_in);
      check_val(tag, {29'd0, tx_out, ready_out, busy_out}, 32'b110);
    end
  endtask

  task automatic start_byte(input logic [DW-1:0] b);
    @(negedge clk_in);
    check_val("ready_at_offer", {31'd0, ready_out}, 32'd1);
    data_in  = b;
    valid_in = 1'b1;
  endtask

  // Expected line after an accepting edge: each listed bit for DIV cycles, then idle.
  // chain: leave valid high with nxt so it is taken on the idle re-entry cycle.
  // abort_at: frame cycle index after which reset is asserted (-1 = none).
  task automatic run_frame(input logic [DW-1:0] b, input bit noise, input bit chain,
                           input logic [DW-1:0] nxt, input int abort_at);
    bit q[$];
    int cyc = 0;
    int busy_cnt = 0;
    bit last;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(b[i]);
`ifdef SERIAL_TX_PARITY_EN
    q.push_back(^b);
`endif
    q.push_back(1'b1);

    for (int i = 0; i < q.size(); i++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk_in);
        check_val($sformatf("line_b%02h_bit%0d", b, i),
                  {29'd0, tx_out, ready_out, busy_out}, {29'd0, q[i], 2'b01});
        busy_cnt += int'(busy_out);
        last = (i == q.size() - 1) && (c == DIV - 1);
        if (cyc == abort_at) begin
          rst_in   = 1'b1;
          valid_in = 1'b1;
          data_in  = DW'($urandom);
          return;
        end
        if (last) begin
          valid_in = chain;
          data_in  = chain ? nxt : DW'($urandom);
        end else if (noise) begin
          valid_in = 1'($urandom_range(0, 1));
          data_in  = DW'($urandom);
        end else begin
          valid_in = chain;
          data_in  = chain ? nxt : data_in;
        end
        cyc++;
      end
    end
    check_val($sformatf("busy_cycles_b%02h", b), busy_cnt, q.size() * DIV);
    @(negedge clk_in);
    check_val("idle_reentry", {29'd0, tx_out, ready_out, busy_out}, 32'b110);
  endtask

  initial begin
    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;
    bit            chain;

    rst_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk_in);
    check_val("reset_state", {29'd0, tx_out, ready_out, busy_out}, 32'b110);
    rst_in = 1'b0;
    expect_idle("idle_after_reset", 100);

    // A handshake presented in a reset cycle must not start a frame.
    @(negedge clk_in);
    rst_in   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h00;
    @(negedge clk_in);
    check_val("reset_beats_handshake", {29'd0, tx_out, ready_out, busy_out}, 32'b110);
    rst_in   = 1'b0;
    valid_in = 1'b0;
    expect_idle("idle_after_reset_hs", 2 * DIV);

    start_byte(8'h41);
    run_frame(8'h41, 1'b0, 1'b0, 8'h00, -1);
    expect_idle("idle_after_41", 3);

    // Mid-frame data changes and valid pulses must be ignored.
    start_byte(8'h07);
    run_frame(8'h07, 1'b1, 1'b0, 8'h00, -1);
    expect_idle("no_second_frame", 2 * DIV);

    start_byte(8'h55);
    run_frame(8'h55, 1'b0, 1'b1, 8'hAA, -1);
    run_frame(8'hAA, 1'b0, 1'b0, 8'h00, -1);
    expect_idle("idle_after_chain", 3);

    // Reset during the second cycle of data bit 3.
    start_byte(8'hFF);
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, 4 * DIV + 1);
    @(negedge clk_in);
    check_val("abort_line_high", {29'd0, tx_out, ready_out, busy_out}, 32'b110);
    rst_in   = 1'b0;
    valid_in = 1'b0;
    expect_idle("abort_no_resume", 12 * DIV);

    cur = DW'($urandom);
    start_byte(cur);
    for (int n = 0; n < 10; n++) begin
      nxt   = DW'($urandom);
      chain = (n < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(cur, 1'b1, chain, nxt, -1);
      if (!chain) begin
        expect_idle("rand_gap", 1);
        if (n < 9) start_byte(nxt);
      end
      cur = nxt;
    end
    expect_idle("final_idle", 2 * DIV);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
